output_delta_buffer: RTL and testbench
======================================

# output_delta_buffer

Output-layer error stage, directly downstream of the last-junction feedforward processor set and upstream of the last-junction backprop/update processor sets. Collects the z/fi sigmoid activations produced per cycle for the n output neurons and forms delta = act − y against the sample's one-hot ideal label (sigmoid + cross-entropy cost). Buffers the n deltas and replays them z/fi per cycle through a valid/ready handshake. Also reports the predicted class (argmax) and whether it matches the label.

## Interface
- fi, 4, fan-in of the last junction
- z, 8, weights processed per cycle; lanes L = z/fi
- n, 8, output neurons; must be a multiple of L; beats per sample C = n/L
- width, 16, fixed-point word width
- int_bits, 5, integer bits
- frac_bits, 10, fraction bits; 1.0 = 2^frac_bits

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- act_valid  in  1  activation beat present
- act_ready  out  1  block accepts activation beat
- act_in_package  in  width*L  lane j = neuron b*L+j of beat b; unsigned, range [0, 1.0]
- ideal_in  in  n  one-hot label; sampled on acceptance of beat 0
- del_valid  out  1  delta beat present
- del_ready  in  1  consumer accepts delta beat
- del_out_package  out  width*L  signed deltas, same lane order as input
- pred_valid  out  1  one-cycle pulse: prediction fields valid
- pred_class  out  clog2(n)  index of largest activation
- pred_correct  out  1  ideal bit at pred_class is 1

## Operation
- Two states: FILL, DRAIN. Reset enters FILL.
- FILL: act_ready = 1, del_valid = 0. Beat accepted when act_valid & act_ready. Beat counter b runs 0..C−1.
- On beat 0: register ideal_in into label register; reset running max to the beat-0 values (no compare against stale max).
- Per accepted lane, neuron k = b*L+j: delta[k] = act − (label[k] ? 2^frac_bits : 0), computed at width+1 bits, stored as width-bit two's complement (range [−1.0, 1.0], no saturation needed for width ≥ frac_bits+2).
- Argmax: lanes compared in ascending index order, replace only on strictly greater (unsigned); ties keep the lowest index.
- Acceptance of beat C−1 → DRAIN; drain counter d = 0.
- DRAIN: act_ready = 0, del_valid = 1, del_out_package = delta beat d (lanes d*L .. d*L+L−1). On del_valid & del_ready, d increments; transfer of d = C−1 → FILL, b = 0.
- pred_valid pulses high in the first DRAIN cycle only; pred_class / pred_correct hold until next sample's pulse.
- pred_correct = label[pred_class]; a non-one-hot label is not checked.
- del_out_package = 0 whenever del_valid = 0.
- reset_n low at any time: state FILL, counters 0, buffer/label/max cleared; a partial sample is discarded and never drained.

## Timing
- Reset values: act_ready 1, del_valid 0, del_out_package 0, pred_valid 0, pred_class 0, pred_correct 0.
- Deltas written at the edge accepting the beat; no pipeline stage inside.
- Last input beat accepted at edge t → del_valid and pred_valid high in cycle t+1.
- Minimum drain C cycles; del_out_package and del_valid stable while del_ready = 0.
- Last delta beat transferred at edge u → act_ready high in cycle u+1. Sample throughput ≥ 2C cycles.
- act_valid ignored during DRAIN; del_ready ignored during FILL.

## Test plan
- Defaults, all acts 0x0200 except neuron 3 = 0x0380, ideal 8'b0000_1000 → deltas 0x0200 ×7, neuron 3 = 0xFF80; pred_class 3, pred_correct 1, pred_valid single pulse one cycle after beat 3.
- Same sample, del_ready low 3 cycles on beat 1 → beat 1 data held 3 cycles, act_ready stays 0, drain completes in 7 cycles.
- Neurons 1 and 5 = 0x03FF, rest 0, ideal bit 5 → pred_class 1, pred_correct 0; neuron 5 delta 0xFFFF.
- All acts 0x0000, ideal bit 0 → neuron 0 delta 0xFC00, others 0x0000.
- reset_n low after 2 accepted beats, then 4 fresh beats → exactly one drain of 4 beats containing only fresh data; no del_valid before.
- act_valid held high for two samples, del_ready high → act_ready 0 for 4 drain cycles, sample 2 beat 0 accepted the cycle after sample 1's last delta beat; second pred pulse reflects sample 2 only.

Source files
------------

// File: rtl/output_delta_buffer.sv
// Output-layer error stage: collects sigmoid activations, forms delta = act - label,
// buffers a full sample of deltas, replays them over a valid/ready port and reports argmax.
module output_delta_buffer #(
  parameter int fi        = 4,
  parameter int z         = 8,
  parameter int n         = 8,
  parameter int width     = 16,
  parameter int int_bits  = 5,
  parameter int frac_bits = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         act_valid,
  output logic                         act_ready,
  input  logic [width*(z/fi)-1:0]      act_in_package,
  input  logic [n-1:0]                 ideal_in,
  output logic                         del_valid,
  input  logic                         del_ready,
  output logic [width*(z/fi)-1:0]      del_out_package,
  output logic                         pred_valid,
  output logic [$clog2(n)-1:0]         pred_class,
  output logic                         pred_correct
);

  localparam int L  = z / fi;
  localparam int C  = n / L;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int IW = $clog2(n);
  localparam logic [IW-1:0]  L_IW = IW'(L);
  localparam logic [CW-1:0]  LAST = CW'(C - 1);
  localparam logic [width:0] ONE  = {{width{1'b0}}, 1'b1} << frac_bits;

  if ((n % L) != 0 || width < frac_bits + 2 || int_bits + frac_bits + 1 > width) begin : g_bad_cfg
    $error("output_delta_buffer: inconsistent parameters");
  end

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [CW-1:0]     drain_q, drain_d;
  logic [n-1:0]      label_q;
  logic [width-1:0]  delta_q [n];
  logic [width-1:0]  max_val_q, max_val_d;
  logic [IW-1:0]     max_idx_q, max_idx_d;
  logic              pred_valid_q;
  logic [IW-1:0]     pred_class_q;
  logic              pred_correct_q;

  logic              accept;
  logic              last_beat;
  logic [n-1:0]      label_eff;
  logic [width-1:0]  lane;
  logic [IW-1:0]     k;
  logic [width-1:0]  delta_lane [L];

  assign accept    = (state_q == FILL) && act_valid;
  assign last_beat = (beat_q == LAST);
  // Beat 0 carries the label, so it must be used combinationally on that beat.
  assign label_eff = (beat_q == '0) ? ideal_in : label_q;

  always_comb begin
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    lane      = '0;
    k         = '0;
    for (int j = 0; j < L; j++) begin
      lane = act_in_package[j*width +: width];
      k    = IW'(beat_q) * L_IW + IW'(j);
      delta_lane[j] = width'({1'b0, lane} - (label_eff[k] ? ONE : '0));
      // Strictly greater keeps the lowest index on ties; beat 0 lane 0 seeds the max.
      if ((beat_q == '0 && j == 0) || lane > max_val_d) begin
        max_val_d = lane;
        max_idx_d = k;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    case (state_q)
      FILL: begin
        if (act_valid) begin
          if (last_beat) begin
            state_d = DRAIN;
            beat_d  = '0;
            drain_d = '0;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (del_ready) begin
          if (drain_q == LAST) begin
            state_d = FILL;
            drain_d = '0;
          end else begin
            drain_d = drain_q + CW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= FILL;
      beat_q         <= '0;
      drain_q        <= '0;
      label_q        <= '0;
      max_val_q      <= '0;
      max_idx_q      <= '0;
      pred_valid_q   <= 1'b0;
      pred_class_q   <= '0;
      pred_correct_q <= 1'b0;
      for (int i = 0; i < n; i++) delta_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      drain_q      <= drain_d;
      pred_valid_q <= accept && last_beat;
      if (accept) begin
        if (beat_q == '0) label_q <= ideal_in;
        max_val_q <= max_val_d;
        max_idx_q <= max_idx_d;
        for (int j = 0; j < L; j++) delta_q[IW'(beat_q) * L_IW + IW'(j)] <= delta_lane[j];
        if (last_beat) begin
          pred_class_q   <= max_idx_d;
          pred_correct_q <= label_eff[max_idx_d];
        end
      end
    end
  end

  always_comb begin
    del_out_package = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < L; j++)
        del_out_package[j*width +: width] = delta_q[IW'(drain_q) * L_IW + IW'(j)];
    end
  end

  assign act_ready    = (state_q == FILL);
  assign del_valid    = (state_q == DRAIN);
  assign pred_valid   = pred_valid_q;
  assign pred_class   = pred_class_q;
  assign pred_correct = pred_correct_q;

endmodule

// File: tb/tb_output_delta_buffer.sv
// Scoreboard bench for output_delta_buffer: directed samples push expected delta beats and
// predictions; a negedge monitor pops and compares whenever the DUT transfers or pulses.
module tb_output_delta_buffer;

  localparam int W = 16;
  localparam int L = 2;
  localparam int N = 8;
  localparam int C = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             act_valid = 1'b0;
  logic             act_ready;
  logic [W*L-1:0]   act_in_package = '0;
  logic [N-1:0]     ideal_in = '0;
  logic             del_valid;
  logic             del_ready = 1'b1;
  logic [W*L-1:0]   del_out_package;
  logic             pred_valid;
  logic [2:0]       pred_class;
  logic             pred_correct;

  output_delta_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .act_valid(act_valid), .act_ready(act_ready), .act_in_package(act_in_package),
    .ideal_in(ideal_in),
    .del_valid(del_valid), .del_ready(del_ready), .del_out_package(del_out_package),
    .pred_valid(pred_valid), .pred_class(pred_class), .pred_correct(pred_correct)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  pred_q[$];
  int          dv_cycles = 0;
  logic        prev_dv = 1'b0;
  logic        prev_pv = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] held = '0;
  logic [31:0] mexp;
  logic [3:0]  mpred;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (del_valid) begin
      check("act_ready_in_drain", {31'b0, act_ready}, 32'd0);
      if (stalled) check("hold_data", del_out_package, held);
      if (del_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected no transfer at %0t", del_out_package, $time);
        end else begin
          mexp = exp_q.pop_front();
          if (del_out_package !== mexp) begin
            errors++;
            $display("FAIL delta_beat: got %h expected %h at %0t", del_out_package, mexp, $time);
          end
        end
      end
      stalled   <= !del_ready;
      held      <= del_out_package;
      dv_cycles <= dv_cycles + 1;
    end else begin
      check("del_out_zero", del_out_package, 32'd0);
      stalled <= 1'b0;
    end
    if (pred_valid) begin
      checks++;
      if (prev_dv || !del_valid || prev_pv) begin
        errors++;
        $display("FAIL pred_pulse_timing: prev_dv=%0b dv=%0b prev_pv=%0b expected 0 1 0 at %0t",
                 prev_dv, del_valid, prev_pv, $time);
      end
      checks++;
      if (pred_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pred: got class %0d correct %0b expected no pulse", pred_class, pred_correct);
      end else begin
        mpred = pred_q.pop_front();
        if ({pred_correct, pred_class} !== mpred) begin
          errors++;
          $display("FAIL pred: got correct=%0b class=%0d expected correct=%0b class=%0d",
                   pred_correct, pred_class, mpred[3], mpred[2:0]);
        end
      end
    end
    prev_dv <= del_valid;
    prev_pv <= pred_valid;
  end

  task automatic push_exp(input logic [N*W-1:0] d, input logic [3:0] p);
    for (int b = 0; b < C; b++) exp_q.push_back(d[b*W*L +: W*L]);
    pred_q.push_back(p);
  endtask

  task automatic send(input logic [N*W-1:0] acts, input logic [N-1:0] ideal, input int nbeats,
                      input bit keep, output int wait0);
    int guard;
    wait0 = 0;
    for (int b = 0; b < nbeats; b++) begin
      act_valid      = 1'b1;
      act_in_package = acts[b*W*L +: W*L];
      ideal_in       = ideal;
      guard = 0;
      @(negedge clk);
      while (!act_ready && guard < 50) begin
        if (b == 0) wait0++;
        guard++;
        @(negedge clk);
      end
      if (guard >= 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: act_ready stuck 0 expected 1 (beat %0d)", b);
      end
      @(posedge clk); #1;
    end
    if (!keep) act_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || del_valid) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  localparam logic [N*W-1:0] A1 = 128'h0200_0200_0200_0200_0380_0200_0200_0200;
  localparam logic [N*W-1:0] D1 = 128'h0200_0200_0200_0200_FF80_0200_0200_0200;
  localparam logic [N*W-1:0] A3 = 128'h0000_0000_03FF_0000_0000_0000_03FF_0000;
  localparam logic [N*W-1:0] D3 = 128'h0000_0000_FFFF_0000_0000_0000_03FF_0000;
  localparam logic [N*W-1:0] D4 = 128'h0000_0000_0000_0000_0000_0000_0000_FC00;
  localparam logic [N*W-1:0] AP = 128'h0100_0100_0100_0100_0100_0100_0100_0100;
  localparam logic [N*W-1:0] A5 = 128'h01C0_0180_0140_0100_00C0_0080_0040_0000;
  localparam logic [N*W-1:0] D5 = 128'h01C0_0180_0140_0100_00C0_FC80_0040_0000;
  localparam logic [N*W-1:0] A6 = 128'h0100_0300_0100_0100_0100_0100_0100_0100;
  localparam logic [N*W-1:0] D6 = 128'h0100_FF00_0100_0100_0100_0100_0100_0100;

  initial begin
    int w, d0;
    repeat (2) @(negedge clk);
    check("rst_act_ready", {31'b0, act_ready}, 32'd1);
    check("rst_del_valid", {31'b0, del_valid}, 32'd0);
    check("rst_del_out", del_out_package, 32'd0);
    check("rst_pred", {28'b0, pred_valid, pred_correct, pred_class}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // one hot neuron 3, correct prediction
    push_exp(D1, 4'hB);
    d0 = dv_cycles;
    send(A1, 8'b0000_1000, C, 1'b0, w);
    wait_drain();
    check("t1_drain_len", dv_cycles - d0, 32'd4);

    // same sample, consumer stalls 3 cycles on beat 1
    push_exp(D1, 4'hB);
    d0 = dv_cycles;
    send(A1, 8'b0000_1000, C, 1'b0, w);
    @(posedge clk); #1;
    del_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 del_ready = 1'b1;
    wait_drain();
    check("t2_drain_len", dv_cycles - d0, 32'd7);

    // tie between neurons 1 and 5, label 5
    push_exp(D3, 4'h1);
    d0 = dv_cycles;
    send(A3, 8'b0010_0000, C, 1'b0, w);
    wait_drain();
    check("t3_drain_len", dv_cycles - d0, 32'd4);

    // reset after two beats discards the partial sample
    send(AP, 8'b1000_0000, 2, 1'b0, w);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_act_ready", {31'b0, act_ready}, 32'd1);
    check("mid_rst_pred", {28'b0, pred_valid, pred_correct, pred_class}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    push_exp(D5, 4'h7);
    d0 = dv_cycles;
    send(A5, 8'b0000_0100, C, 1'b0, w);
    wait_drain();
    check("t5_drain_len", dv_cycles - d0, 32'd4);

    // all zero activations, label 0
    push_exp(D4, 4'h8);
    send('0, 8'b0000_0001, C, 1'b0, w);
    wait_drain();

    // back-to-back samples with act_valid held high
    push_exp(D1, 4'hB);
    push_exp(D6, 4'hE);
    d0 = dv_cycles;
    send(A1, 8'b0000_1000, C, 1'b1, w);
    send(A6, 8'b0100_0000, C, 1'b0, w);
    check("t6_beat0_wait", w, 32'd4);
    wait_drain();
    check("t6_drain_len", dv_cycles - d0, 32'd8);

    check("leftover_deltas", exp_q.size(), 32'd0);
    check("leftover_preds", pred_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
